// File: rtl/glitc_program_ctrl_if.sv
// Wishbone slave bundle between the TISC register space and the GLITC sequencer.
// Latency: none (wires only).
// Backpressure: none; the slave acks every accepted strobe one cycle later.
//
// Signal names are taken from the slave's point of view:
//   cyc_i/stb_i/we_i, adr_i[3:0], dat_i[31:0], sel_i[3:0]  -> into the slave
//   dat_o[31:0], ack_o, err_o, rty_o                       <- out of the slave
interface glitc_program_ctrl_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output dat_o, ack_o, err_o, rty_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  dat_o, ack_o, err_o, rty_o
    );
endinterface

// File: rtl/glitc_program_ctrl.sv
// Per-GLITC configuration sequencer: PROGRAM_B/INIT_B drive, INIT_B/DONE watch, gready flags.
// Latency: Wishbone ack one cycle after strobe; pad-to-FSM 2 sync cycles + 1 transition.
// Backpressure: none; back-to-back strobes are acked every other cycle.
//
// Ports: clk_i/rst_i (sync, active-high); wb = Wishbone slave (CTRL/STATUS at 0x0,
// STATE at 0x4); program_b_o/init_b_t_o drive the pads; init_b_i/done_i are async
// pad levels; gready_o[N]=1 means GLITC N is configured and usable on GLITCBUS.
module glitc_program_ctrl #(
    parameter int PROG_CYCLES      = 100,
    parameter int INIT_HOLD_CYCLES = 100,
    parameter int INIT_TIMEOUT     = 100000,
    parameter int LOAD_TIMEOUT     = 100000000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    glitc_program_ctrl_if.slave wb,
    output logic [3:0]          program_b_o,
    output logic [3:0]          init_b_t_o,
    input  logic [3:0]          init_b_i,
    input  logic [3:0]          done_i,
    output logic [3:0]          gready_o
);

    localparam int MAX_A   = (PROG_CYCLES  > INIT_HOLD_CYCLES) ? PROG_CYCLES  : INIT_HOLD_CYCLES;
    localparam int MAX_B   = (INIT_TIMEOUT > LOAD_TIMEOUT)     ? INIT_TIMEOUT : LOAD_TIMEOUT;
    localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    // Counters start at 0 on phase entry, so the last cycle of a phase is LIMIT-1.
    localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(INIT_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PROG      = 3'd1,
        ST_INIT_HOLD = 3'd2,
        ST_WAIT_INIT = 3'd3,
        ST_LOADING   = 3'd4,
        ST_READY     = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    state_t           state_q [4];
    state_t           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       err_q, err_d;

    logic [3:0] init_meta, init_sync;
    logic [3:0] done_meta, done_sync;

    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rdata;
    logic        req;
    logic [3:0]  start;
    logic [3:0]  busy;

    // Address/data bits that carry no register meaning.
    logic unused_bits;
    assign unused_bits = ^{wb.dat_i[31:4], wb.sel_i[3:1], wb.adr_i[1:0]};

    // A strobe held through its own ack cycle is not a new request.
    assign req   = wb.cyc_i & wb.stb_i & ~ack_q;
    assign start = (req && wb.we_i && (wb.adr_i[3:2] == 2'd0) && wb.sel_i[0]) ?
                   wb.dat_i[3:0] : 4'h0;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            err_d[n]   = err_q[n];
            if (start[n]) begin
                state_d[n] = ST_PROG;
                cnt_d[n]   = '0;
                err_d[n]   = 1'b0;
            end else begin
                case (state_q[n])
                    ST_PROG: begin
                        if (cnt_q[n] == PROG_LAST) begin
                            state_d[n] = ST_INIT_HOLD;
                            cnt_d[n]   = '0;
                        end else begin
                            cnt_d[n] = cnt_q[n] + CNT_W'(1);
                        end
                    end
                    ST_INIT_HOLD: begin
                        if (cnt_q[n] == HOLD_LAST) begin
                            state_d[n] = ST_WAIT_INIT;
                            cnt_d[n]   = '0;
                        end else begin
                            cnt_d[n] = cnt_q[n] + CNT_W'(1);
                        end
                    end
                    // Pin success is tested before the timeout so it wins a tie.
                    ST_WAIT_INIT: begin
                        if (init_sync[n]) begin
                            state_d[n] = ST_LOADING;
                            cnt_d[n]   = '0;
                        end else if (cnt_q[n] == INIT_LAST) begin
                            state_d[n] = ST_ERROR;
                            cnt_d[n]   = '0;
                            err_d[n]   = 1'b1;
                        end else begin
                            cnt_d[n] = cnt_q[n] + CNT_W'(1);
                        end
                    end
                    ST_LOADING: begin
                        if (done_sync[n]) begin
                            state_d[n] = ST_READY;
                            cnt_d[n]   = '0;
                        end else if (cnt_q[n] == LOAD_LAST) begin
                            state_d[n] = ST_ERROR;
                            cnt_d[n]   = '0;
                            err_d[n]   = 1'b1;
                        end else begin
                            cnt_d[n] = cnt_q[n] + CNT_W'(1);
                        end
                    end
                    // DONE dropping means the GLITC was reconfigured or upset.
                    ST_READY: begin
                        if (!done_sync[n]) state_d[n] = ST_IDLE;
                    end
                    ST_IDLE, ST_ERROR: ;
                    default: state_d[n] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        program_b_o = 4'hF;
        init_b_t_o  = 4'hF;
        gready_o    = 4'h0;
        busy        = 4'h0;
        for (int n = 0; n < 4; n++) begin
            program_b_o[n] = (state_q[n] != ST_PROG);
            init_b_t_o[n]  = (state_q[n] != ST_PROG) && (state_q[n] != ST_INIT_HOLD);
            gready_o[n]    = (state_q[n] == ST_READY);
            busy[n]        = (state_q[n] == ST_PROG)      || (state_q[n] == ST_INIT_HOLD) ||
                             (state_q[n] == ST_WAIT_INIT) || (state_q[n] == ST_LOADING);
        end
    end

    always_comb begin
        rdata = '0;
        case (wb.adr_i[3:2])
            2'd0: rdata = {12'h000, busy, err_q, init_sync, done_sync, gready_o};
            2'd1: begin
                for (int n = 0; n < 4; n++) rdata[4*n +: 3] = state_q[n];
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= ST_IDLE;
                cnt_q[n]   <= '0;
            end
            err_q     <= 4'h0;
            init_meta <= 4'h0;
            init_sync <= 4'h0;
            done_meta <= 4'h0;
            done_sync <= 4'h0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
            err_q     <= err_d;
            init_meta <= init_b_i;
            init_sync <= init_meta;
            done_meta <= done_i;
            done_sync <= done_meta;
            ack_q     <= wb.cyc_i & wb.stb_i & ~ack_q;
            dat_q     <= req ? rdata : 32'h0;
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.dat_o = dat_q;
    assign wb.err_o = 1'b0;
    assign wb.rty_o = 1'b0;

endmodule

// File: tb/tb_glitc_program_ctrl.sv
// Directed bench for glitc_program_ctrl with short phase lengths.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: bus ops wait a bounded number of cycles for ack.
module tb_glitc_program_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  program_b_o, init_b_t_o, gready_o;
    logic [3:0]  init_b_i, done_i;
    logic [31:0] rd;
    int          n_chk = 0;
    int          n_err = 0;
    int          cnt;
    logic        mon_g2;
    logic        g2_seen;

    glitc_program_ctrl_if bus();

    glitc_program_ctrl #(
        .PROG_CYCLES      (4),
        .INIT_HOLD_CYCLES (4),
        .INIT_TIMEOUT     (16),
        .LOAD_TIMEOUT     (64)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .wb          (bus.slave),
        .program_b_o (program_b_o),
        .init_b_t_o  (init_b_t_o),
        .init_b_i    (init_b_i),
        .done_i      (done_i),
        .gready_o    (gready_o)
    );

    always #5 clk = ~clk;

    // Latches any gready_o[2] assertion while the GLITC2 load-timeout window is open.
    always @(negedge clk) begin
        if (!mon_g2)          g2_seen <= 1'b0;
        else if (gready_o[2]) g2_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge where ack_o is seen.
    task automatic wb_op(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                         output logic [31:0] rdat);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr;
        bus.dat_i = wd;
        bus.sel_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ack_o) break;
        end
        check("wb_ack", 32'(bus.ack_o), 32'h1);
        rdat      = bus.dat_o;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_i     = 1'b1;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = 4'h0;
        bus.dat_i = 32'h0;
        bus.sel_i = 4'h0;
        init_b_i  = 4'h0;
        done_i    = 4'h0;
        mon_g2    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_program_b", 32'(program_b_o), 32'hF);
        check("rst_init_b_t",  32'(init_b_t_o),  32'hF);
        check("rst_gready",    32'(gready_o),    32'h0);
        check("rst_dat_o",     bus.dat_o,        32'h0);
        rst_i = 1'b0;
        wb_op(1'b0, 4'h0, 32'h0, rd);
        check("rst_status", rd, 32'h0);
        wb_op(1'b0, 4'hC, 32'h0, rd);
        check("unmapped_read", rd, 32'h0);
        @(negedge clk);
        check("ack_pulse", 32'(bus.ack_o), 32'h0);

        // GLITC0 full program sequence
        wb_op(1'b1, 4'h0, 32'h1, rd);
        cnt = 0;
        while (program_b_o[0] == 1'b0 && cnt < 50) begin cnt++; @(negedge clk); end
        check("g0_prog_len", 32'(cnt), 32'd4);
        cnt = 0;
        while (init_b_t_o[0] == 1'b0 && cnt < 50) begin cnt++; @(negedge clk); end
        check("g0_hold_len", 32'(cnt), 32'd4);
        init_b_i[0] = 1'b1;
        repeat (10) @(negedge clk);
        done_i[0]   = 1'b1;
        // INIT_B is dropped so the status word isolates DONE/READY.
        init_b_i[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("g0_gready_early", 32'(gready_o[0]), 32'h0);
        @(negedge clk);
        check("g0_gready_rise", 32'(gready_o[0]), 32'h1);
        wb_op(1'b0, 4'h0, 32'h0, rd);
        check("g0_status", rd, 32'h0000_0011);

        // GLITC1 INIT timeout (init_b_i[1] held low)
        wb_op(1'b1, 4'h0, 32'h2, rd);
        repeat (23) @(negedge clk);
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("g1_wait_init_last", (rd >> 4) & 32'h7, 32'd3);
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("g1_error_state", (rd >> 4) & 32'h7, 32'd6);
        wb_op(1'b0, 4'h0, 32'h0, rd);
        check("g1_error_status", rd, 32'h0000_2011);
        wb_op(1'b1, 4'h0, 32'h2, rd);
        wb_op(1'b0, 4'h0, 32'h0, rd);
        check("g1_error_cleared", rd, 32'h0002_0011);

        // GLITC2 load timeout (DONE never rises)
        mon_g2 = 1'b1;
        wb_op(1'b1, 4'h0, 32'h4, rd);
        cnt = 0;
        while (init_b_t_o[2] == 1'b0 && cnt < 50) begin cnt++; @(negedge clk); end
        check("g2_release_time", 32'(cnt), 32'd8);
        init_b_i[2] = 1'b1;
        repeat (2) @(negedge clk);
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("g2_sync_before", (rd >> 8) & 32'h7, 32'd3);
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("g2_sync_after", (rd >> 8) & 32'h7, 32'd4);
        repeat (61) @(negedge clk);
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("g2_loading_last", (rd >> 8) & 32'h7, 32'd4);
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("g2_load_timeout", (rd >> 8) & 32'h7, 32'd6);
        check("g2_gready_never", 32'(g2_seen), 32'h0);
        mon_g2 = 1'b0;
        wb_op(1'b0, 4'h0, 32'h0, rd);
        check("g2_error_bit", (rd >> 14) & 32'h1, 32'h1);

        // GLITC0 loses DONE
        done_i[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("g0_gready_hold", 32'(gready_o[0]), 32'h1);
        @(negedge clk);
        check("g0_gready_drop", 32'(gready_o[0]), 32'h0);
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("g0_idle", rd & 32'h7, 32'd0);
        check("g2_unaffected", (rd >> 8) & 32'h7, 32'd6);

        // Restart all while GLITC1 is loading, then reset mid-PROG
        init_b_i[1] = 1'b1;
        wb_op(1'b1, 4'h0, 32'h2, rd);
        repeat (20) @(negedge clk);
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("g1_loading", (rd >> 4) & 32'h7, 32'd4);
        wb_op(1'b1, 4'h0, 32'hF, rd);
        check("all_prog_pb",   32'(program_b_o), 32'h0);
        check("all_prog_init", 32'(init_b_t_o),  32'h0);
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("all_prog_state", rd, 32'h0000_1111);
        rst_i = 1'b1;
        @(negedge clk);
        check("midrst_program_b", 32'(program_b_o), 32'hF);
        check("midrst_init_b_t",  32'(init_b_t_o),  32'hF);
        check("midrst_gready",    32'(gready_o),    32'h0);
        rst_i = 1'b0;
        wb_op(1'b0, 4'h4, 32'h0, rd);
        check("post_rst_state", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/glitc_program_ctrl.md
# glitc_program_ctrl

Per-GLITC configuration sequencer for the TISC board: a Wishbone slave in TISC register space that drives PROGRAM_B and INIT_B for each of the four GLITC FPGAs, watches INIT_B/DONE, and produces `gready_o[3:0]`. Those flags feed `gready_i` of the GLITCBUS master directly downstream. A GLITC with `gready_o[N]=0` has its GLITCBUS accesses treated as SelectMAP configuration writes; `gready_o[N]=1` means normal register transactions. Each GLITC is programmed/reprogrammed independently.

## Interface
Parameters:
- PROG_CYCLES, 100: clk_i cycles PROGRAM_B held low.
- INIT_HOLD_CYCLES, 100: cycles INIT_B held low after PROGRAM_B release.
- INIT_TIMEOUT, 100000: max cycles waiting for INIT_B high.
- LOAD_TIMEOUT, 100000000: max cycles waiting for DONE high.
- Counter width per GLITC = $clog2(max of the above + 1).

Ports (clocking is decided: one clock `clk_i`; reset `rst_i` is synchronous, active-high):
- clk_i  in  1  system clock (same clock as GLITCBUS master)
- rst_i  in  1  synchronous active-high reset
- cyc_i, stb_i, we_i  in  1 each  Wishbone slave strobes
- adr_i  in  4  byte address; adr_i[3:2] selects register
- dat_i  in  32  write data
- sel_i  in  4  byte selects
- dat_o  out  32  read data
- ack_o  out  1  acknowledge
- err_o, rty_o  out  1 each  tied 0
- program_b_o  out  4  PROGRAM_B per GLITC (0 = asserted)
- init_b_t_o  out  4  INIT_B tristate (0 = drive low, 1 = release)
- init_b_i  in  4  INIT_B pad level (async)
- done_i  in  4  DONE pad level (async)
- gready_o  out  4  GLITC N configured and usable on GLITCBUS

## Operation
- init_b_i, done_i: two-flop synchronizers each; logic uses synchronized copies only.
- Per-GLITC FSM (3-bit encoding): IDLE=0, PROG=1, INIT_HOLD=2, WAIT_INIT=3, LOADING=4, READY=5, ERROR=6.
- Outputs decoded from state register: program_b_o[N]=0 only in PROG; init_b_t_o[N]=0 in PROG and INIT_HOLD; gready_o[N]=1 only in READY.
- Transitions:
  - any state -> PROG on start[N]; counter cleared; error[N] cleared.
  - PROG -> INIT_HOLD after PROG_CYCLES cycles.
  - INIT_HOLD -> WAIT_INIT after INIT_HOLD_CYCLES cycles.
  - WAIT_INIT -> LOADING when init_sync[N]=1; -> ERROR after INIT_TIMEOUT cycles.
  - LOADING -> READY when done_sync[N]=1; -> ERROR after LOAD_TIMEOUT cycles.
  - READY -> IDLE if done_sync[N] falls (external reconfig/upset).
- ERROR sets sticky error[N], cleared only by start or reset.
- Registers:
  - adr[3:2]=0 CTRL/STATUS.
    - Write with sel_i[0]: dat_i[3:0]=1 generates start[N].
    - Read: [3:0] gready, [7:4] done_sync, [11:8] init_sync, [15:12] error, [19:16] busy (PROG/INIT_HOLD/WAIT_INIT/LOADING), rest 0.
  - adr[3:2]=1 STATE read-only: state N at bits [4N+2:4N].
  - Other addresses: read 0, writes ignored.

## Timing
- Reset: all FSMs IDLE, counters 0, error 0, program_b_o=4'hF, init_b_t_o=4'hF, gready_o=0, ack_o=0, dat_o=0, synchronizers 0.
- ack_o <= cyc_i & stb_i & ~ack_o: single-cycle pulse one cycle after strobe. Back-to-back strobes are acked every other cycle.
- dat_o is registered and valid with ack_o.
- Start decoded on the request cycle; FSM in PROG the cycle ack_o is high.
- Phase durations are exact: PROG lasts PROG_CYCLES cycles, INIT_HOLD lasts INIT_HOLD_CYCLES cycles.
- Pad-to-FSM latency is 2 cycles (synchronizer) plus 1 transition cycle.
- A timeout fires on the cycle the counter reaches the limit. If the synchronized pin rises that same cycle, success wins.
- Start while busy restarts at PROG. A start while in ERROR also enters PROG.
- rst_i mid-sequence releases PROGRAM_B/INIT_B on the next edge.

## Test plan
Bench parameters: PROG_CYCLES=4, INIT_HOLD_CYCLES=4, INIT_TIMEOUT=16, LOAD_TIMEOUT=64.
- Reset, then read adr 0 -> dat_o=0. Outputs: program_b_o=F, init_b_t_o=F, gready_o=0.
- Write adr 0 = 0x1. Model releases INIT_B on release, raises done_i[0] 10 cycles later.
  - program_b_o[0] low exactly 4 cycles, then init_b_t_o[0] low 4 more.
  - gready_o[0]=1 3 cycles after DONE. Status read = 0x0000_0011.
- Write 0x2 with init_b_i[1] held low -> ERROR after 16 WAIT_INIT cycles. Status bit 13 set, STATE bits[6:4]=6. Rewriting 0x2 clears bit 13.
- Write 0x4 with DONE never rising -> ERROR after 64 LOADING cycles. gready_o[2] stays 0 throughout.
- GLITC0 READY, then drop done_i[0] -> gready_o[0]=0 within 3 cycles, state IDLE. Other GLITCs unaffected.
- Write 0xF while GLITC1 mid-LOADING -> all four enter PROG simultaneously. rst_i asserted mid-PROG -> next edge program_b_o=F, gready_o=0.
